// File: rtl/naive_bus_arbiter.sv
// Two-master / one-slave naive_bus arbiter with independent read and write channels.
// Define NAIVE_BUS_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise m0 has fixed priority.
module naive_bus_arbiter (
   input  logic        clk,
   input  logic        rst,
   // master port 0 (data access)
   input  logic        m0_rd_req,
   output logic        m0_rd_gnt,
   input  logic [31:0] m0_rd_addr,
   input  logic [3:0]  m0_rd_be,
   output logic [31:0] m0_rd_data,
   input  logic        m0_wr_req,
   output logic        m0_wr_gnt,
   input  logic [31:0] m0_wr_addr,
   input  logic [3:0]  m0_wr_be,
   input  logic [31:0] m0_wr_data,
   // master port 1 (instruction fetch)
   input  logic        m1_rd_req,
   output logic        m1_rd_gnt,
   input  logic [31:0] m1_rd_addr,
   input  logic [3:0]  m1_rd_be,
   output logic [31:0] m1_rd_data,
   input  logic        m1_wr_req,
   output logic        m1_wr_gnt,
   input  logic [31:0] m1_wr_addr,
   input  logic [3:0]  m1_wr_be,
   input  logic [31:0] m1_wr_data,
   // downstream port toward the slave/router
   output logic        s_rd_req,
   input  logic        s_rd_gnt,
   output logic [31:0] s_rd_addr,
   output logic [3:0]  s_rd_be,
   input  logic [31:0] s_rd_data,
   output logic        s_wr_req,
   input  logic        s_wr_gnt,
   output logic [31:0] s_wr_addr,
   output logic [3:0]  s_wr_be,
   output logic [31:0] s_wr_data
);

   logic sel_rd;
   logic sel_wr;
   logic rd_own_vld_q, rd_own_vld_d;
   logic rd_own_idx_q, rd_own_idx_d;

`ifdef NAIVE_BUS_ARB_ROUND_ROBIN_EN
   logic rd_last_q, rd_last_d;
   logic wr_last_q, wr_last_d;

   // Under contention the master that did not win last time is chosen.
   always_comb begin
      sel_rd = (m0_rd_req & m1_rd_req) ? ~rd_last_q : (~m0_rd_req & m1_rd_req);
      sel_wr = (m0_wr_req & m1_wr_req) ? ~wr_last_q : (~m0_wr_req & m1_wr_req);
   end

   always_comb begin
      rd_last_d = rd_last_q;
      wr_last_d = wr_last_q;
      if (s_rd_req & s_rd_gnt) rd_last_d = sel_rd;
      if (s_wr_req & s_wr_gnt) wr_last_d = sel_wr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_last_q <= 1'b1;
         wr_last_q <= 1'b1;
      end else begin
         rd_last_q <= rd_last_d;
         wr_last_q <= wr_last_d;
      end
   end
`else
   always_comb begin
      sel_rd = ~m0_rd_req & m1_rd_req;
      sel_wr = ~m0_wr_req & m1_wr_req;
   end
`endif

   always_comb begin
      s_rd_req  = m0_rd_req | m1_rd_req;
      s_rd_addr = 32'd0;
      s_rd_be   = 4'd0;
      if (s_rd_req) begin
         s_rd_addr = sel_rd ? m1_rd_addr : m0_rd_addr;
         s_rd_be   = sel_rd ? m1_rd_be   : m0_rd_be;
      end

      s_wr_req  = m0_wr_req | m1_wr_req;
      s_wr_addr = 32'd0;
      s_wr_be   = 4'd0;
      s_wr_data = 32'd0;
      if (s_wr_req) begin
         s_wr_addr = sel_wr ? m1_wr_addr : m0_wr_addr;
         s_wr_be   = sel_wr ? m1_wr_be   : m0_wr_be;
         s_wr_data = sel_wr ? m1_wr_data : m0_wr_data;
      end

      m0_rd_gnt = ~sel_rd & m0_rd_req & s_rd_gnt;
      m1_rd_gnt =  sel_rd & m1_rd_req & s_rd_gnt;
      m0_wr_gnt = ~sel_wr & m0_wr_req & s_wr_gnt;
      m1_wr_gnt =  sel_wr & m1_wr_req & s_wr_gnt;
   end

   // Read data returns one cycle after the handshake, steered to the owner of that handshake.
   always_comb begin
      rd_own_vld_d = s_rd_req & s_rd_gnt;
      rd_own_idx_d = sel_rd;
      m0_rd_data   = (rd_own_vld_q & ~rd_own_idx_q) ? s_rd_data : 32'd0;
      m1_rd_data   = (rd_own_vld_q &  rd_own_idx_q) ? s_rd_data : 32'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_own_vld_q <= 1'b0;
         rd_own_idx_q <= 1'b0;
      end else begin
         rd_own_vld_q <= rd_own_vld_d;
         rd_own_idx_q <= rd_own_idx_d;
      end
   end

endmodule
